// File: rtl/icache_refill_server_pkg.sv
// icache_refill_server_pkg: shared FSM states, RV32I NOP and line addressing helper.
package icache_refill_server_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, ABORT} fillState_t;
  localparam logic [31:0] RV32I_NOP = 32'h00000013;
  function automatic logic [31:0] lineBase(input logic [31:0] addr, input int blockSize);
    return addr & ~(32'(blockSize) - 32'd1);
  endfunction
endpackage

// File: rtl/icache_refill_server.sv
// icache_refill_server: fetches an aligned cache line word-by-word and returns it packed, lowest word in the MSBs.
module icache_refill_server
  import icache_refill_server_pkg::*;
#(
  parameter int          BLOCK_SIZE = 32,
  parameter int          TIMEOUT    = 255,
  parameter logic [31:0] FILL_WORD  = RV32I_NOP
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    memRead,
  input  logic [31:0]             memAddress,
  output logic                    memBusy,
  output logic [BLOCK_SIZE*8-1:0] memReadData,
  output logic                    wordReq,
  output logic [31:0]             wordAddr,
  input  logic                    wordAck,
  input  logic [31:0]             wordData,
  output logic                    fillErr
);
  localparam int N_WORDS = BLOCK_SIZE / 4;
  localparam int IW = N_WORDS > 1 ? $clog2(N_WORDS) : 1;
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  fillState_t state, stateNext;
  logic [31:0] base;
  logic [IW-1:0] wordIdx;
  logic [TW-1:0] tmo;
  logic [N_WORDS-1:0][31:0] line;
  logic lastWord, timedOut;
  assign lastWord = wordIdx == IW'(N_WORDS - 1);
  assign timedOut = TIMEOUT != 0 && !wordAck && tmo == TW'(TIMEOUT - 1);
  assign wordReq = state == FETCH;
  assign wordAddr = wordReq ? base + 32'({wordIdx, 2'b00}) : '0;
  always_comb begin
    stateNext = state == IDLE  ? (memRead ? FETCH : IDLE) :
                state == FETCH ? (wordAck && lastWord ? IDLE : timedOut ? ABORT : FETCH) :
                IDLE;
  end
  // slot k holds the word at base+4k; it lands in the k-th 32-bit field from the top
  for (genvar k = 0; k < N_WORDS; k++) begin : g_pack
    assign memReadData[BLOCK_SIZE*8-1-32*k -: 32] = line[k];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      base    <= '0;
      wordIdx <= '0;
      tmo     <= '0;
      line    <= '0;
      memBusy <= 1'b0;
      fillErr <= 1'b0;
    end else begin
      state <= stateNext;
      if (state == IDLE && memRead) begin
        base    <= lineBase(memAddress, BLOCK_SIZE);
        wordIdx <= '0;
        tmo     <= '0;
        memBusy <= 1'b1;
      end
      if (state == FETCH) begin
        if (wordAck) begin
          line[wordIdx] <= wordData;
          wordIdx       <= wordIdx + IW'(1);
          tmo           <= '0;
          memBusy       <= !lastWord;
        end else if (tmo != '1) begin
          tmo <= tmo + TW'(1);
        end
      end
      if (state == ABORT) begin
        for (int k = 0; k < N_WORDS; k++)
          if (IW'(k) >= wordIdx) line[IW'(k)] <= FILL_WORD;
        fillErr <= 1'b1;
        memBusy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_icache_refill_server.sv
// tb_icache_refill_server: scoreboard bench with a configurable stalling word memory.
module tb_icache_refill_server;
  localparam int BS = 32;
  localparam int NW = BS / 4;
  localparam int TMO = 4;
  localparam int LW = BS * 8;
  logic clk = 1'b0, rst = 1'b0, memRead = 1'b0, wordAck = 1'b0;
  logic [31:0] memAddress = '0, wordData = '0;
  logic memBusy, wordReq, fillErr;
  logic [31:0] wordAddr;
  logic [LW-1:0] memReadData;
  int total = 0, bad = 0;
  int waitFor[NW];
  int dropFrom = NW, widx = 0, waitCnt = 0;
  logic expErr = 1'b0;
  logic [31:0] expAddrQ[$];
  logic [LW-1:0] lineQ[$];
  int busyQ[$];

  icache_refill_server #(.BLOCK_SIZE(BS), .TIMEOUT(TMO), .FILL_WORD(32'h00000013)) dut (
    .clk(clk), .rst(rst), .memRead(memRead), .memAddress(memAddress), .memBusy(memBusy),
    .memReadData(memReadData), .wordReq(wordReq), .wordAddr(wordAddr), .wordAck(wordAck),
    .wordData(wordData), .fillErr(fillErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // backing memory: returns its own address as data, stalls/drops per config
  always @(negedge clk) begin
    wordAck = 1'b0;
    if (rst && wordReq && widx < dropFrom) begin
      if (waitCnt < waitFor[widx]) waitCnt++;
      else begin
        wordAck = 1'b1;
        wordData = wordAddr;
        check("addrQueued", LW'(expAddrQ.size() != 0), LW'(1));
        if (expAddrQ.size() != 0) check("wordAddr", LW'(wordAddr), LW'(expAddrQ.pop_front()));
        widx++;
        waitCnt = 0;
      end
    end
  end

  task automatic setCfg(input int drop, input int stallWord, input int stallCycles);
    dropFrom = drop;
    for (int k = 0; k < NW; k++) waitFor[k] = k == stallWord ? stallCycles : 0;
  endtask

  task automatic pushExpected(input logic [31:0] addr);
    logic [31:0] base;
    logic [LW-1:0] line;
    int nAck, busy;
    base = addr & ~32'(BS - 1);
    nAck = dropFrom < NW ? dropFrom : NW;
    busy = nAck;
    for (int k = 0; k < NW; k++) begin
      if (k < nAck) begin
        expAddrQ.push_back(base + 32'(4 * k));
        busy += waitFor[k];
      end
      line[LW-1-32*k -: 32] = k < nAck ? base + 32'(4 * k) : 32'h00000013;
    end
    if (dropFrom < NW) begin
      busy += TMO + 1;
      expErr = 1'b1;
    end
    lineQ.push_back(line);
    busyQ.push_back(busy);
  endtask

  task automatic doFill(input logic [31:0] addr, input int pulseAt);
    int n;
    logic [LW-1:0] expLine;
    widx = 0;
    waitCnt = 0;
    pushExpected(addr);
    memRead = 1'b1;
    memAddress = addr;
    @(negedge clk);
    n = 0;
    while (memBusy && n < 100) begin
      n++;
      memRead = n == pulseAt;
      memAddress = n == pulseAt ? 32'h0000_0500 : addr;
      @(negedge clk);
    end
    memRead = 1'b0;
    expLine = lineQ.pop_front();
    check("busyCycles", LW'(n), LW'(busyQ.pop_front()));
    check("line", memReadData, expLine);
    check("fillErr", LW'(fillErr), LW'(expErr));
    check("addrLeft", LW'(expAddrQ.size()), LW'(0));
    repeat (3) @(negedge clk);
    check("idleBusy", LW'({memBusy, wordReq}), LW'(0));
    check("lineHeld", memReadData, expLine);
  endtask

  task automatic checkReset(input string tag);
    check({tag, "Busy"}, LW'(memBusy), LW'(0));
    check({tag, "Req"}, LW'(wordReq), LW'(0));
    check({tag, "Addr"}, LW'(wordAddr), LW'(0));
    check({tag, "Data"}, memReadData, LW'(0));
    check({tag, "Err"}, LW'(fillErr), LW'(0));
  endtask

  initial begin
    int n;
    setCfg(NW, 0, 0);
    repeat (3) @(negedge clk);
    checkReset("rstHold");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkReset("rstIdle");
    doFill(32'h0000_0104, 0);
    setCfg(NW, 4, 3);
    doFill(32'h0000_0104, 0);
    setCfg(2, 0, 0);
    doFill(32'h2000_0048, 7);
    setCfg(NW, 0, 0);
    doFill(32'h2000_0048, 0);
    doFill(32'h0000_0030, 3);
    doFill(32'hFFFF_FFF4, 0);
    // reset in the middle of a fill
    widx = 0;
    waitCnt = 0;
    for (int k = 0; k < NW; k++) expAddrQ.push_back(32'h0000_0200 + 32'(4 * k));
    memRead = 1'b1;
    memAddress = 32'h0000_0210;
    @(negedge clk);
    memRead = 1'b0;
    n = 0;
    while (widx < 5 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("reachWord5", LW'(widx >= 5), LW'(1));
    rst = 1'b0;
    #1;
    checkReset("midRst");
    expAddrQ.delete();
    expErr = 1'b0;
    @(negedge clk);
    checkReset("midRstHold");
    rst = 1'b1;
    @(negedge clk);
    doFill(32'h0000_0404, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
